// File: rtl/neopix_frame_ctrl.sv
// rtl/neopix_frame_ctrl.sv - double-buffered LED pixel store with swap-on-gap and brightness scaling
module neopix_frame_ctrl #(
    parameter int NUM_LEDS = 4
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        wr_en,
    input  logic [$clog2(NUM_LEDS)-1:0] wr_addr,
    input  logic [23:0]                 wr_data,
    input  logic [7:0]                  bright_in,
    input  logic                        commit,
    output logic                        swap_pending,
    output logic [15:0]                 frame_count,
    input  logic                        drv_reset_state,
    input  logic                        drv_data_request,
    input  logic [$clog2(NUM_LEDS)-1:0] drv_address,
    output logic [7:0]                  red_out,
    output logic [7:0]                  green_out,
    output logic [7:0]                  blue_out
);

    localparam int AW = $clog2(NUM_LEDS);
    localparam logic [AW:0] LED_LIMIT = (AW+1)'(NUM_LEDS);

    localparam logic [0:0] ST_IDLE    = 1'b0;
    localparam logic [0:0] ST_PENDING = 1'b1;

    logic [23:0] bank0 [NUM_LEDS];
    logic [23:0] bank1 [NUM_LEDS];
    logic        front_sel;
    logic [7:0]  bright_shadow;
    logic [0:0]  state;
    logic [0:0]  state_nxt;
    logic        do_swap;
    logic        wr_in_range;
    logic        drv_in_range;
    logic [23:0] front_pix;

    function automatic logic [7:0] scale(input logic [7:0] c, input logic [7:0] b);
        logic [15:0] prod;
        prod = {8'd0, c} * ({8'd0, b} + 16'd1);
        return prod[15:8];
    endfunction

    assign wr_in_range  = ({1'b0, wr_addr} < LED_LIMIT);
    assign drv_in_range = ({1'b0, drv_address} < LED_LIMIT);

    // Swapping only while the driver is idle in its gap keeps every frame from a single bank.
    assign do_swap      = (state == ST_PENDING) && drv_reset_state && !drv_data_request;
    assign swap_pending = (state == ST_PENDING);

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (commit) begin
                    state_nxt = ST_PENDING;
                end
            end
            ST_PENDING: begin
                if (do_swap) begin
                    state_nxt = commit ? ST_PENDING : ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= ST_IDLE;
            front_sel     <= 1'b0;
            bright_shadow <= 8'hFF;
            frame_count   <= 16'd0;
        end else begin
            state <= state_nxt;
            if (do_swap) begin
                front_sel     <= ~front_sel;
                bright_shadow <= bright_in;
                frame_count   <= frame_count + 16'd1;
            end
        end
    end

    // Host writes target the bank that is back before this edge, so a write racing a swap lands in the new front.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_LEDS; i++) begin
                bank0[i] <= 24'd0;
                bank1[i] <= 24'd0;
            end
        end else if (wr_en && wr_in_range) begin
            if (front_sel) begin
                bank0[wr_addr] <= wr_data;
            end else begin
                bank1[wr_addr] <= wr_data;
            end
        end
    end

    always_comb begin
        front_pix = 24'd0;
        if (drv_in_range) begin
            front_pix = front_sel ? bank1[drv_address] : bank0[drv_address];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            red_out   <= 8'd0;
            green_out <= 8'd0;
            blue_out  <= 8'd0;
        end else if (drv_data_request) begin
            red_out   <= scale(front_pix[23:16], bright_shadow);
            green_out <= scale(front_pix[15:8],  bright_shadow);
            blue_out  <= scale(front_pix[7:0],   bright_shadow);
        end
    end

endmodule

// File: doc/neopix_frame_ctrl.md
NEOPIX_FRAME_CTRL -- requirements
Module: neopix_frame_ctrl

Interface
REQ-001 The module SHALL have parameter NUM_LEDS, default 4, number of LEDs in the chain, legal range 2..1024.
REQ-002 The module SHALL have port clk, input, 1 bit: the single system clock; all state SHALL change on its rising edge.
REQ-003 The module SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 The module SHALL have port wr_en, input, 1 bit: host pixel write strobe.
REQ-005 The module SHALL have port wr_addr, input, $clog2(NUM_LEDS) bits: host pixel index.
REQ-006 The module SHALL have port wr_data, input, 24 bits: host pixel value {R[23:16], G[15:8], B[7:0]}.
REQ-007 The module SHALL have port bright_in, input, 8 bits: global brightness request.
REQ-008 The module SHALL have port commit, input, 1 bit: single-cycle pulse requesting a buffer swap.
REQ-009 The module SHALL have port swap_pending, output, 1 bit: a commit is waiting for the next frame gap.
REQ-010 The module SHALL have port frame_count, output, 16 bits: number of completed swaps.
REQ-011 The module SHALL have port drv_reset_state, input, 1 bit: the LED driver is in its inter-frame reset gap.
REQ-012 The module SHALL have port drv_data_request, input, 1 bit: the driver samples pixel data on the next cycle.
REQ-013 The module SHALL have port drv_address, input, $clog2(NUM_LEDS) bits: the LED index the driver is about to latch.
REQ-014 The module SHALL have ports red_out, green_out and blue_out, each output, 8 bits: pixel data to the driver.

Function
REQ-015 Storage SHALL consist of two banks of NUM_LEDS x 24 bits; one bank is front (displayed) and the other is back (host-written).
REQ-016 A write with wr_en=1 and wr_addr<NUM_LEDS SHALL update back[wr_addr] on that edge; a write with wr_addr>=NUM_LEDS SHALL be ignored.
REQ-017 The front bank SHALL never be written by the host port.
REQ-018 On an edge where drv_data_request=1, red_out, green_out and blue_out SHALL be registered from front[drv_address] scaled, so they are valid on the cycle after the request.
REQ-019 Scaling SHALL be out = (c x (bright_shadow+1)) >> 8 per channel, using 16-bit intermediates, no rounding, no saturation.
REQ-020 When bright_shadow=255, out SHALL equal c.
REQ-021 When drv_data_request=0, red_out, green_out and blue_out SHALL hold their values.
REQ-022 A request with drv_address>=NUM_LEDS SHALL load 0 into red_out, green_out and blue_out.
REQ-023 The swap FSM SHALL have two states: IDLE and PENDING; swap_pending SHALL be 1 exactly in PENDING.
REQ-024 In IDLE, commit=1 SHALL move the FSM to PENDING.
REQ-025 In PENDING, a swap SHALL occur on the first edge where drv_reset_state=1 and drv_data_request=0.
REQ-026 A swap SHALL exchange front and back, copy bright_in into bright_shadow, increment frame_count by 1 (wrapping 0xFFFF->0), and move the FSM to IDLE.
REQ-027 In PENDING, commit=1 with no swap on that edge SHALL have no additional effect.
REQ-028 commit=1 on the same edge as a swap SHALL leave the FSM in PENDING, re-armed for the next gap.
REQ-029 A pixel read triggered by drv_data_request SHALL use the front bank as it stood before any swap on that edge; a swap SHALL never occur mid-frame (drv_reset_state=0).
REQ-030 A host write and a swap on the same edge SHALL write the pre-swap back bank, which becomes the new front.
REQ-031 After a swap, the back bank SHALL contain the previous front data; the host SHALL rewrite every pixel it wants changed.

Reset
REQ-032 When reset_n=0, the following SHALL be set asynchronously: both banks all-zero, bank0 front, bright_shadow=255, FSM IDLE, swap_pending=0, frame_count=0, red_out=green_out=blue_out=0.
REQ-033 Reset asserted mid-frame or while PENDING SHALL discard the pending commit and all pixel data.
REQ-034 Release of reset_n SHALL be synchronised by the integrating level; the block itself SHALL NOT require internal synchronisation.

Verification
REQ-035 Write back[1]=0x102030, commit during a gap -> swap on next gap cycle; then request with drv_address=1 -> next cycle R=0x10, G=0x20, B=0x30; frame_count=1.
REQ-036 commit while drv_reset_state=0 -> swap_pending=1 and outputs unchanged for the whole frame; swap on the first gap cycle with drv_data_request=0; swap_pending then 0.
REQ-037 bright_in=127, pixel 0xFF8001, commit -> scaled outputs R=0x7F, G=0x40, B=0x00.
REQ-038 commit on the swap edge -> swap_pending remains 1 and a second swap occurs in the next gap (frame_count +2); wr_addr=NUM_LEDS -> no storage change.
REQ-039 frame_count preloaded via 65535 swaps -> the next swap wraps it to 0.
REQ-040 reset_n pulsed low while PENDING mid-frame -> all outputs 0, swap_pending=0, and a request for any address returns 0.
